// File: rtl/stim_capture_pkg.sv
// Shared types and constants for the stimulus/capture engine.
package stim_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    localparam logic MODE_COUNT = 1'b0;
    localparam logic MODE_LFSR  = 1'b1;

    // Toggle masks for a right-shifting Galois LFSR; bit (t-1) is set for each tap t.
    // Widths outside 2..16 return 0, which makes the generator fall back to counting.
    function automatic logic [15:0] lfsr_taps(int w);
        logic [15:0] mask;
        case (w)
            2:       mask = 16'h0003;
            3:       mask = 16'h0006;
            4:       mask = 16'h000C;
            5:       mask = 16'h0014;
            6:       mask = 16'h0030;
            7:       mask = 16'h0060;
            8:       mask = 16'h00B8;
            9:       mask = 16'h0110;
            10:      mask = 16'h0240;
            11:      mask = 16'h0500;
            12:      mask = 16'h0829;
            13:      mask = 16'h100D;
            14:      mask = 16'h2015;
            15:      mask = 16'h6000;
            16:      mask = 16'hD008;
            default: mask = 16'h0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/stim_capture_engine_fifo.sv
// Show-ahead capture FIFO: dout always presents the oldest entry while not empty.
module sc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         CK,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // The extra pointer MSB separates "full" from "empty" when the address bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; a push and a pop on a full FIFO both proceed and occupancy stays put.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are meaningless until the write pointer passes them.
    always_ff @(posedge CK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/stim_capture_engine.sv
// Stimulus generator and response capture: drives vectors, waits, and queues {vector, response}.
module stim_capture_engine
    import stim_capture_pkg::*;
#(
    parameter int IN_W       = 1,
    parameter int OUT_W      = 1,
    parameter int NUM_PAT    = 2,
    parameter int SETTLE_CYC = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  CK,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [IN_W-1:0]       seed,
    output logic [IN_W-1:0]       dut_in,
    input  logic [OUT_W-1:0]      dut_out,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [IN_W+OUT_W-1:0] rd_data,
    output logic                  busy,
    output logic                  done
);

    localparam int              PCW         = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
    localparam logic [PCW-1:0]  LAST_PAT    = PCW'(NUM_PAT - 1);
    localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [15:0]     TAPS16      = lfsr_taps(IN_W);
    localparam logic [IN_W-1:0] TAPS        = TAPS16[IN_W-1:0];
    localparam bit              LFSR_OK     = (IN_W >= 2);

    if (IN_W < 1 || IN_W > 16) begin : g_bad_in_w
        $error("stim_capture_engine: IN_W must be 1..16");
    end
    if (NUM_PAT < 1 || NUM_PAT > (1 << IN_W)) begin : g_bad_num_pat
        $error("stim_capture_engine: NUM_PAT must be 1..2**IN_W");
    end
    if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
        $error("stim_capture_engine: SETTLE_CYC must be 1..255");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stim_capture_engine: FIFO_DEPTH must be a power of two >= 2");
    end

    state_t         state;
    logic [IN_W-1:0] vec;
    logic [IN_W-1:0] vec_next;
    logic [PCW-1:0]  pat_cnt;
    logic [7:0]      settle_cnt;
    logic            run_mode;
    logic            fifo_full;
    logic            fifo_empty;
    logic            capture_ok;

    // A capture may go ahead when there is room, or when the reader frees a slot this same cycle.
    assign capture_ok = (state == CAPTURE) && (!fifo_full || rd_ready);
    assign rd_valid   = !fifo_empty;

    // Next vector: Galois right-shift LFSR, or a plain wrapping counter.
    always_comb begin
        vec_next = vec + 1'b1;
        if (run_mode == MODE_LFSR && LFSR_OK) begin
            vec_next = vec >> 1;
            if (vec[0]) vec_next = vec_next ^ TAPS;
        end
    end

    // Run sequencer with registered dut_in, busy and done.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vec        <= '0;
            dut_in     <= '0;
            pat_cnt    <= '0;
            settle_cnt <= '0;
            run_mode   <= MODE_COUNT;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        run_mode <= mode;
                        if (mode == MODE_LFSR && LFSR_OK)
                            vec <= (seed == '0) ? IN_W'(1) : seed;
                        else
                            vec <= '0;
                        pat_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    dut_in     <= vec;
                    settle_cnt <= SETTLE_LOAD;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == 8'd0)
                        state <= CAPTURE;
                    else
                        settle_cnt <= settle_cnt - 8'd1;
                end
                CAPTURE: begin
                    if (capture_ok) begin
                        if (pat_cnt == LAST_PAT) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            pat_cnt <= pat_cnt + 1'b1;
                            vec     <= vec_next;
                            state   <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sc_fifo #(
        .W     (IN_W + OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CK    (CK),
        .reset (reset),
        .push  (capture_ok),
        .pop   (rd_ready),
        .full  (fifo_full),
        .empty (fifo_empty),
        .din   ({vec, dut_out}),
        .dout  (rd_data)
    );

endmodule

// File: tb/tb_stim_capture_engine.sv
// Self-checking bench for stim_capture_engine across four parameterisations.
module tb_stim_capture_engine;

    logic CK = 1'b0;
    logic reset;

    always #5 CK = ~CK;

    // Instance 1: defaults, DUT is an inverter
    logic       s1_start, s1_mode, s1_rd_ready, s1_rd_valid, s1_busy, s1_done;
    logic [0:0] s1_seed, s1_dut_in, s1_dut_out;
    logic [1:0] s1_rd_data;
    assign s1_dut_out = ~s1_dut_in;

    // Instance 2: 4-bit count, 16 patterns, identity DUT
    logic       s2_start, s2_mode, s2_rd_ready, s2_rd_valid, s2_busy, s2_done;
    logic [3:0] s2_seed, s2_dut_in, s2_dut_out;
    logic [7:0] s2_rd_data;
    assign s2_dut_out = s2_dut_in;

    // Instance 3: 4-bit, 15 patterns, identity DUT
    logic       s3_start, s3_mode, s3_rd_ready, s3_rd_valid, s3_busy, s3_done;
    logic [3:0] s3_seed, s3_dut_in, s3_dut_out;
    logic [7:0] s3_rd_data;
    assign s3_dut_out = s3_dut_in;

    // Instance 4: 4-deep FIFO, 10 patterns, identity DUT
    logic       s4_start, s4_mode, s4_rd_ready, s4_rd_valid, s4_busy, s4_done;
    logic [3:0] s4_seed, s4_dut_in, s4_dut_out;
    logic [7:0] s4_rd_data;
    assign s4_dut_out = s4_dut_in;

    stim_capture_engine u1 (
        .CK(CK), .reset(reset), .start(s1_start), .mode(s1_mode), .seed(s1_seed),
        .dut_in(s1_dut_in), .dut_out(s1_dut_out), .rd_valid(s1_rd_valid),
        .rd_ready(s1_rd_ready), .rd_data(s1_rd_data), .busy(s1_busy), .done(s1_done)
    );

    stim_capture_engine #(.IN_W(4), .OUT_W(4), .NUM_PAT(16), .SETTLE_CYC(1), .FIFO_DEPTH(8)) u2 (
        .CK(CK), .reset(reset), .start(s2_start), .mode(s2_mode), .seed(s2_seed),
        .dut_in(s2_dut_in), .dut_out(s2_dut_out), .rd_valid(s2_rd_valid),
        .rd_ready(s2_rd_ready), .rd_data(s2_rd_data), .busy(s2_busy), .done(s2_done)
    );

    stim_capture_engine #(.IN_W(4), .OUT_W(4), .NUM_PAT(15), .SETTLE_CYC(1), .FIFO_DEPTH(8)) u3 (
        .CK(CK), .reset(reset), .start(s3_start), .mode(s3_mode), .seed(s3_seed),
        .dut_in(s3_dut_in), .dut_out(s3_dut_out), .rd_valid(s3_rd_valid),
        .rd_ready(s3_rd_ready), .rd_data(s3_rd_data), .busy(s3_busy), .done(s3_done)
    );

    stim_capture_engine #(.IN_W(4), .OUT_W(4), .NUM_PAT(10), .SETTLE_CYC(1), .FIFO_DEPTH(4)) u4 (
        .CK(CK), .reset(reset), .start(s4_start), .mode(s4_mode), .seed(s4_seed),
        .dut_in(s4_dut_in), .dut_out(s4_dut_out), .rd_valid(s4_rd_valid),
        .rd_ready(s4_rd_ready), .rd_data(s4_rd_data), .busy(s4_busy), .done(s4_done)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    typedef struct {
        logic       mode;
        logic [3:0] seed;
        logic [3:0] exp_first;
    } lfsr_case_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic sel_valid(input int s);
        case (s)
            1:       return s1_rd_valid;
            2:       return s2_rd_valid;
            3:       return s3_rd_valid;
            default: return s4_rd_valid;
        endcase
    endfunction

    function automatic logic sel_ready(input int s);
        case (s)
            1:       return s1_rd_ready;
            2:       return s2_rd_ready;
            3:       return s3_rd_ready;
            default: return s4_rd_ready;
        endcase
    endfunction

    function automatic logic [7:0] sel_data(input int s);
        case (s)
            1:       return {6'b0, s1_rd_data};
            2:       return s2_rd_data;
            3:       return s3_rd_data;
            default: return s4_rd_data;
        endcase
    endfunction

    function automatic logic sel_busy(input int s);
        case (s)
            1:       return s1_busy;
            2:       return s2_busy;
            3:       return s3_busy;
            default: return s4_busy;
        endcase
    endfunction

    function automatic logic sel_done(input int s);
        case (s)
            1:       return s1_done;
            2:       return s2_done;
            3:       return s3_done;
            default: return s4_done;
        endcase
    endfunction

    task automatic set_start(input int s, input logic v);
        case (s)
            1:       s1_start = v;
            2:       s2_start = v;
            3:       s3_start = v;
            default: s4_start = v;
        endcase
    endtask

    task automatic set_ready(input int s, input logic v);
        case (s)
            1:       s1_rd_ready = v;
            2:       s2_rd_ready = v;
            3:       s3_rd_ready = v;
            default: s4_rd_ready = v;
        endcase
    endtask

    // Launch a run: start is raised on a falling edge and dropped by applyStimulus on the next one.
    task automatic launch(input int s);
        @(negedge CK);
        set_start(s, 1'b1);
    endtask

    // Drive one run to completion, comparing each popped entry against the scoreboard (or
    // collecting it for instance 3), and recording done/busy timing relative to the start cycle.
    task automatic applyStimulus(input int s, input int n, input int budget, input int ready_at,
                                 input int poke_at, output int done_cyc, output int done_cnt,
                                 output int busy_fall, output int got);
        int  cyc;
        int  tail;
        logic prev_busy;
        logic [7:0] d;
        logic [7:0] e;
        cyc = 0; tail = 0; got = 0; done_cnt = 0; done_cyc = -1; busy_fall = -1;
        prev_busy = 1'b1;
        while (cyc < budget && tail < 6) begin
            @(negedge CK);
            cyc++;
            set_start(s, (poke_at > 0) && (cyc == poke_at || cyc == poke_at + 20));
            set_ready(s, cyc >= ready_at);
            if (ready_at > 1 && cyc == ready_at - 1) begin
                checkOutput("stall_busy", 32'(sel_busy(s)), 32'd1);
                checkOutput("stall_no_done", 32'(done_cnt), 32'd0);
                checkOutput("stall_valid", 32'(sel_valid(s)), 32'd1);
            end
            if (sel_valid(s) && sel_ready(s)) begin
                d = sel_data(s);
                got++;
                if (s == 3) begin
                    got_q.push_back(d);
                end else if (exp_q.size() == 0) begin
                    checkOutput("extra_entry", 32'(d), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("entry", 32'(d), 32'(e));
                end
            end
            if (sel_done(s)) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_busy && !sel_busy(s) && busy_fall < 0) busy_fall = cyc;
            prev_busy = sel_busy(s);
            if (got >= n && done_cnt > 0) tail++;
        end
        set_start(s, 1'b0);
        checkOutput("entry_count", 32'(got), 32'(n));
    endtask

    initial begin
        lfsr_case_t cases[3];
        int done_cyc, done_cnt, busy_fall, got;
        int found;
        logic [15:0] seen;
        int dups, zeros;
        logic [3:0] v;

        cases[0] = '{mode: 1'b1, seed: 4'h0, exp_first: 4'h1};
        cases[1] = '{mode: 1'b1, seed: 4'h9, exp_first: 4'h9};
        cases[2] = '{mode: 1'b0, seed: 4'h7, exp_first: 4'h0};

        reset = 1'b1;
        s1_start = 0; s2_start = 0; s3_start = 0; s4_start = 0;
        s1_mode = 0;  s2_mode = 0;  s3_mode = 0;  s4_mode = 0;
        s1_seed = '0; s2_seed = '0; s3_seed = '0; s4_seed = '0;
        s1_rd_ready = 1; s2_rd_ready = 1; s3_rd_ready = 1; s4_rd_ready = 1;
        repeat (3) @(negedge CK);
        checkOutput("rst_dut_in", 32'(s2_dut_in), 32'd0);
        checkOutput("rst_busy", 32'(s2_busy), 32'd0);
        checkOutput("rst_done", 32'(s1_done), 32'd0);
        checkOutput("rst_valid", 32'(s4_rd_valid), 32'd0);
        reset = 1'b0;
        @(negedge CK);

        // Test 1: inverter, two vectors
        $display("[TB] test 1: defaults with inverter");
        exp_q.push_back(8'b01);
        exp_q.push_back(8'b10);
        launch(1);
        applyStimulus(1, 2, 100, 0, 0, done_cyc, done_cnt, busy_fall, got);
        checkOutput("t1_done_cnt", 32'(done_cnt), 32'd1);
        checkOutput("t1_done_cyc", 32'(done_cyc), 32'(1 + 2 * 3));
        checkOutput("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // Test 2: exhaustive count with identity DUT
        $display("[TB] test 2: count 16 identity");
        for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 4'(i)});
        launch(2);
        applyStimulus(2, 16, 200, 0, 0, done_cyc, done_cnt, busy_fall, got);
        checkOutput("t2_done_cnt", 32'(done_cnt), 32'd1);
        checkOutput("t2_done_cyc", 32'(done_cyc), 32'(1 + 16 * 3));
        checkOutput("t2_busy_fall", 32'(busy_fall), 32'(done_cyc + 1));
        checkOutput("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // Test 3: table of LFSR/count runs on the 15-pattern instance
        $display("[TB] test 3: LFSR table");
        for (int c = 0; c < 3; c++) begin
            got_q.delete();
            s3_mode = cases[c].mode;
            s3_seed = cases[c].seed;
            launch(3);
            applyStimulus(3, 15, 200, 0, 0, done_cyc, done_cnt, busy_fall, got);
            checkOutput("t3_done_cnt", 32'(done_cnt), 32'd1);
            if (got_q.size() == 15) begin
                checkOutput("t3_first", 32'(got_q[0][7:4]), 32'(cases[c].exp_first));
                seen = '0; dups = 0; zeros = 0;
                for (int i = 0; i < 15; i++) begin
                    v = got_q[i][7:4];
                    checkOutput("t3_resp", 32'(got_q[i][3:0]), 32'(v));
                    if (cases[c].mode == 1'b0) checkOutput("t3_count_vec", 32'(v), 32'(i));
                    if (seen[v]) dups++;
                    seen[v] = 1'b1;
                    if (v == 4'h0) zeros++;
                end
                checkOutput("t3_distinct", 32'(dups), 32'd0);
                if (cases[c].mode == 1'b1) checkOutput("t3_nonzero", 32'(zeros), 32'd0);
            end
        end

        // Test 4: reader stalled until cycle 60 on a 4-deep FIFO
        $display("[TB] test 4: back-pressure");
        for (int i = 0; i < 10; i++) exp_q.push_back({4'(i), 4'(i)});
        launch(4);
        applyStimulus(4, 10, 300, 60, 0, done_cyc, done_cnt, busy_fall, got);
        checkOutput("t4_done_cnt", 32'(done_cnt), 32'd1);
        checkOutput("t4_done_late", 32'(done_cyc > 60), 32'd1);
        checkOutput("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // Test 5: reset during SETTLE of vector 3, then a clean rerun
        $display("[TB] test 5: reset mid-run");
        s2_rd_ready = 1'b0;
        launch(2);
        @(negedge CK);
        s2_start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (s2_dut_in == 4'd3) found = 1;
            else @(negedge CK);
        end
        checkOutput("t5_reached_vec3", 32'(found), 32'd1);
        checkOutput("t5_pre_valid", 32'(s2_rd_valid), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("t5_rst_dut_in", 32'(s2_dut_in), 32'd0);
        checkOutput("t5_rst_busy", 32'(s2_busy), 32'd0);
        checkOutput("t5_rst_done", 32'(s2_done), 32'd0);
        checkOutput("t5_rst_valid", 32'(s2_rd_valid), 32'd0);
        @(negedge CK);
        reset = 1'b0;
        s2_rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 4'(i)});
        launch(2);
        applyStimulus(2, 16, 200, 0, 0, done_cyc, done_cnt, busy_fall, got);
        checkOutput("t5_done_cyc", 32'(done_cyc), 32'(1 + 16 * 3));
        checkOutput("t5_q_empty", 32'(exp_q.size()), 32'd0);

        // Test 6: extra start pulses while busy must not disturb the run
        $display("[TB] test 6: start while busy");
        for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 4'(i)});
        launch(2);
        applyStimulus(2, 16, 200, 0, 10, done_cyc, done_cnt, busy_fall, got);
        checkOutput("t6_done_cnt", 32'(done_cnt), 32'd1);
        checkOutput("t6_done_cyc", 32'(done_cyc), 32'(1 + 16 * 3));
        checkOutput("t6_idle_after", 32'(s2_busy), 32'd0);
        checkOutput("t6_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
